// File: rtl/multicycle_sequencer.sv
// Control sequencer for the multi-cycle LEGv8 datapath.
// A single-clock FSM walks each instruction through FETCH, DECODE, EXECUTE,
// an optional MEMORY stage and WRITEBACK, and issues one enable strobe per stage.
//
// Memory handshake: fetch_req / dmem_req act as "valid" and are held high for
// every cycle the FSM sits in FETCH / MEMORY. The matching ready input completes
// the transfer in the cycle where request and ready are both high. The FSM never
// drops a request before ready, unless the wait limit expires (then it goes to ERROR).
module multicycle_sequencer #(
  parameter int CNT_W         = 32,
  parameter int DECODE_CYCLES = 1,
  parameter int EXEC_CYCLES   = 1,
  parameter int TIMEOUT       = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic             step,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  input  logic             mem_access,
  input  logic             reg_write,
  output logic             fetch_req,
  output logic             ir_load,
  output logic             rf_read_en,
  output logic             alu_en,
  output logic             dmem_req,
  output logic             rf_write_en,
  output logic             pc_load,
  output logic [2:0]       phase,
  output logic             busy,
  output logic             timeout,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_MEMORY    = 3'd4,
    S_WRITEBACK = 3'd5,
    S_ERROR     = 3'd7
  } state_t;

  // The stage counter covers the longer of DECODE and EXECUTE.
  // The wait counter must be able to hold TIMEOUT.
  localparam int MAX_CYC = (DECODE_CYCLES > EXEC_CYCLES) ? DECODE_CYCLES : EXEC_CYCLES;
  localparam int PC_W    = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam int WC_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam bit TO_EN   = (TIMEOUT > 0);

  localparam logic [PC_W-1:0] DEC_LAST  = PC_W'(DECODE_CYCLES - 1);
  localparam logic [PC_W-1:0] EXE_LAST  = PC_W'(EXEC_CYCLES - 1);
  localparam logic [WC_W-1:0] WAIT_LAST = WC_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_t          state;
  state_t          next_state;
  logic [PC_W-1:0] phase_cnt;
  logic [WC_W-1:0] wait_cnt;
  logic            wait_expired;

  // True in the last allowed waiting cycle. A ready in the same cycle still wins,
  // because the ready branches below are tested first.
  assign wait_expired = TO_EN && (wait_cnt == WAIT_LAST);

  // Next-state and strobe decode from the current state and the ready inputs.
  always_comb begin
    next_state  = state;
    fetch_req   = 1'b0;
    ir_load     = 1'b0;
    rf_read_en  = 1'b0;
    alu_en      = 1'b0;
    dmem_req    = 1'b0;
    rf_write_en = 1'b0;
    pc_load     = 1'b0;
    case (state)
      S_IDLE: begin
        // step alone or run alone both start an instruction
        if (run || step) next_state = S_FETCH;
      end
      S_FETCH: begin
        fetch_req = 1'b1;
        if (imem_ready) begin
          ir_load    = 1'b1;
          next_state = S_DECODE;
        end else if (wait_expired) begin
          next_state = S_ERROR;
        end
      end
      S_DECODE: begin
        rf_read_en = 1'b1;
        if (phase_cnt == DEC_LAST) next_state = S_EXECUTE;
      end
      S_EXECUTE: begin
        alu_en = 1'b1;
        if (phase_cnt == EXE_LAST) next_state = mem_access ? S_MEMORY : S_WRITEBACK;
      end
      S_MEMORY: begin
        dmem_req = 1'b1;
        if (dmem_ready) begin
          next_state = S_WRITEBACK;
        end else if (wait_expired) begin
          next_state = S_ERROR;
        end
      end
      S_WRITEBACK: begin
        rf_write_en = reg_write;
        pc_load     = 1'b1;
        next_state  = run ? S_FETCH : S_IDLE;
      end
      S_ERROR: begin
        next_state = S_ERROR;
      end
      default: begin
        next_state = S_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) state <= S_IDLE;
    else        state <= next_state;
  end

  // Stage counter: counts cycles spent in DECODE or EXECUTE, cleared on every state change.
  always_ff @(posedge clk) begin
    if (!reset) begin
      phase_cnt <= '0;
    end else if ((state == S_DECODE || state == S_EXECUTE) && next_state == state) begin
      phase_cnt <= phase_cnt + 1'b1;
    end else begin
      phase_cnt <= '0;
    end
  end

  // Wait counter: counts cycles without ready in FETCH or MEMORY, cleared on entry.
  // With the timeout enabled it never passes WAIT_LAST. With TIMEOUT=0 it may wrap;
  // this is harmless because it is then never compared.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wait_cnt <= '0;
    end else if ((state == S_FETCH || state == S_MEMORY) && next_state == state) begin
      wait_cnt <= wait_cnt + 1'b1;
    end else begin
      wait_cnt <= '0;
    end
  end

  // Retired-instruction counter: bumps at the end of each WRITEBACK, wraps silently.
  always_ff @(posedge clk) begin
    if (!reset)                      instr_count <= '0;
    else if (state == S_WRITEBACK)   instr_count <= instr_count + 1'b1;
  end

  assign phase   = state;
  assign busy    = (state == S_FETCH) || (state == S_DECODE) || (state == S_EXECUTE) ||
                   (state == S_MEMORY) || (state == S_WRITEBACK);
  // ERROR is only left through reset, so the flag is sticky by construction.
  assign timeout = (state == S_ERROR);

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Self-checking bench for multicycle_sequencer (CNT_W=4, other parameters default).
module tb_multicycle_sequencer;

  logic       clk = 1'b0;
  logic       reset, run, step, imem_ready, dmem_ready, mem_access, reg_write;
  logic       fetch_req, ir_load, rf_read_en, alu_en, dmem_req, rf_write_en, pc_load;
  logic       busy, timeout;
  logic [2:0] phase;
  logic [3:0] instr_count;
  logic [15:0] obs;

  int errors = 0;
  int checks = 0;
  int model_count = 0;

  typedef struct packed {
    logic        run;
    logic        step;
    logic        imem;
    logic        dmem;
    logic        mem;
    logic        rw;
    logic [15:0] exp;
  } cyc_t;

  cyc_t plan[$];

  always #5 clk = ~clk;

  multicycle_sequencer #(
    .CNT_W(4), .DECODE_CYCLES(1), .EXEC_CYCLES(1), .TIMEOUT(15)
  ) dut (
    .clk(clk), .reset(reset), .run(run), .step(step),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .mem_access(mem_access), .reg_write(reg_write),
    .fetch_req(fetch_req), .ir_load(ir_load), .rf_read_en(rf_read_en),
    .alu_en(alu_en), .dmem_req(dmem_req), .rf_write_en(rf_write_en),
    .pc_load(pc_load), .phase(phase), .busy(busy), .timeout(timeout),
    .instr_count(instr_count)
  );

  // Observed vector: {phase, strobes, busy, timeout, instr_count}
  assign obs = {phase, fetch_req, ir_load, rf_read_en, alu_en, dmem_req, rf_write_en,
                pc_load, busy, timeout, instr_count};

  // Expected observation from the stage table: which strobe each stage raises.
  function automatic logic [15:0] exp_obs(int ph, logic imem, logic rw, logic to, int cnt);
    logic [6:0] s;
    logic       b;
    case (ph)
      1:       s = {1'b1, imem, 5'b00000};
      2:       s = 7'b0010000;
      3:       s = 7'b0001000;
      4:       s = 7'b0000100;
      5:       s = {5'b00000, rw, 1'b1};
      default: s = 7'b0000000;
    endcase
    b = (ph >= 1) && (ph <= 5);
    return {3'(ph), s, b, to, 4'(cnt)};
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [15:0] e;
    reset = 1'b0; run = 1'b1; step = 1'b0; imem_ready = 1'b1; dmem_ready = 1'b1;
    mem_access = 1'b0; reg_write = 1'b1;
    model_count = 0;
    for (int i = 0; i < 2; i++) begin
      cycle();
      @(negedge clk);
      e = exp_obs(0, imem_ready, reg_write, 1'b0, model_count);
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL reset_state cycle %0d got=%h exp=%h", i, obs, e);
      end
    end
    run = 1'b0;
    reset = 1'b1;
    cycle();
  endtask

  task automatic test_continuous_run();
    int seq[4] = '{1, 2, 3, 5};
    int tail[5] = '{1, 2, 3, 5, 0};
    logic [15:0] e;
    run = 1'b1; step = 1'b0; imem_ready = 1'b1; dmem_ready = 1'b1;
    mem_access = 1'b0; reg_write = 1'b1;
    @(negedge clk);
    e = exp_obs(0, 1'b1, 1'b1, 1'b0, model_count);
    checks++;
    if (obs !== e) begin
      errors++;
      $display("FAIL run_idle got=%h exp=%h", obs, e);
    end
    cycle();
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      e = exp_obs(seq[i % 4], 1'b1, 1'b1, 1'b0, model_count);
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL run_cycle %0d got=%h exp=%h", i, obs, e);
      end
      if (seq[i % 4] == 5) model_count++;
      cycle();
    end
    // drop run at the start of the fourth instruction: it completes, then IDLE
    run = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      e = exp_obs(tail[i], 1'b1, 1'b1, 1'b0, model_count);
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL run_drain %0d got=%h exp=%h", i, obs, e);
      end
      if (tail[i] == 5) model_count++;
      cycle();
    end
  endtask

  task automatic test_single_step_memory();
    int ph_l[10] = '{1, 2, 3, 4, 4, 4, 5, 0, 0, 0};
    logic dr[10] = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0};
    logic [15:0] e;
    run = 1'b0; step = 1'b1; imem_ready = 1'b1; dmem_ready = 1'b0;
    mem_access = 1'b1; reg_write = 1'b1;
    @(negedge clk);
    e = exp_obs(0, 1'b1, 1'b1, 1'b0, model_count);
    checks++;
    if (obs !== e) begin
      errors++;
      $display("FAIL step_idle got=%h exp=%h", obs, e);
    end
    cycle();
    step = 1'b0;
    for (int i = 0; i < 10; i++) begin
      dmem_ready = dr[i];
      @(negedge clk);
      e = exp_obs(ph_l[i], 1'b1, 1'b1, 1'b0, model_count);
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL step_mem cycle %0d got=%h exp=%h", i, obs, e);
      end
      if (ph_l[i] == 5) model_count++;
      cycle();
    end
  endtask

  task automatic test_ready_wins();
    int tail[4] = '{2, 3, 5, 0};
    logic [15:0] e;
    run = 1'b0; step = 1'b1; imem_ready = 1'b0; dmem_ready = 1'b0;
    mem_access = 1'b0; reg_write = 1'b0;
    cycle();
    step = 1'b0;
    // ready arrives in the 15th FETCH cycle, exactly at the limit
    for (int i = 0; i < 15; i++) begin
      imem_ready = (i == 14);
      @(negedge clk);
      e = exp_obs(1, imem_ready, 1'b0, 1'b0, model_count);
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL ready_wins_fetch %0d got=%h exp=%h", i, obs, e);
      end
      cycle();
    end
    imem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      e = exp_obs(tail[i], 1'b0, 1'b0, 1'b0, model_count);
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL ready_wins_tail %0d got=%h exp=%h", i, obs, e);
      end
      if (tail[i] == 5) model_count++;
      cycle();
    end
  endtask

  task automatic test_reset_mid_memory();
    int ph_l[5] = '{1, 2, 3, 4, 4};
    logic [15:0] e;
    run = 1'b0; step = 1'b1; imem_ready = 1'b1; dmem_ready = 1'b0;
    mem_access = 1'b1; reg_write = 1'b1;
    cycle();
    step = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i == 4) reset = 1'b0;
      @(negedge clk);
      e = exp_obs(ph_l[i], 1'b1, 1'b1, 1'b0, model_count);
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL mid_mem cycle %0d got=%h exp=%h", i, obs, e);
      end
      cycle();
    end
    model_count = 0;
    @(negedge clk);
    e = exp_obs(0, 1'b1, 1'b1, 1'b0, model_count);
    checks++;
    if (obs !== e) begin
      errors++;
      $display("FAIL mid_mem_reset got=%h exp=%h", obs, e);
    end
    reset = 1'b1;
    mem_access = 1'b0;
    cycle();
  endtask

  task automatic test_wrap_and_stop();
    int seq[4] = '{1, 2, 3, 5};
    int tail[6] = '{1, 2, 3, 5, 0, 0};
    logic [15:0] e;
    run = 1'b1; step = 1'b0; imem_ready = 1'b1; dmem_ready = 1'b1;
    mem_access = 1'b0; reg_write = 1'b1;
    cycle();
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      e = exp_obs(seq[i % 4], 1'b1, 1'b1, 1'b0, model_count);
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL wrap_cycle %0d got=%h exp=%h", i, obs, e);
      end
      if (seq[i % 4] == 5) model_count++;
      cycle();
    end
    // 17th instruction: count reads 0 after the wrap; run drops in EXECUTE
    for (int i = 0; i < 6; i++) begin
      if (i == 2) run = 1'b0;
      @(negedge clk);
      e = exp_obs(tail[i], 1'b1, 1'b1, 1'b0, model_count);
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL wrap_stop %0d got=%h exp=%h", i, obs, e);
      end
      if (tail[i] == 5) model_count++;
      cycle();
    end
  endtask

  task automatic push(logic r, logic s, logic im, logic dm, logic m, logic w, int ph);
    cyc_t c;
    c.run = r; c.step = s; c.imem = im; c.dmem = dm; c.mem = m; c.rw = w;
    c.exp = exp_obs(ph, im, w, 1'b0, model_count);
    plan.push_back(c);
  endtask

  // Random instruction mixes: the plan is built from stage rules, then replayed.
  task automatic test_random_mix();
    int n;
    int iw;
    int dw;
    logic m;
    logic w;
    logic last;
    for (int t = 0; t < 4; t++) begin
      plan.delete();
      n = $urandom_range(3, 8);
      push(1'b1, 1'b0, rb(), rb(), rb(), rb(), 0);
      for (int k = 0; k < n; k++) begin
        m = rb(); w = rb(); last = (k == n - 1);
        iw = $urandom_range(0, 3); dw = $urandom_range(0, 3);
        for (int j = 0; j < iw; j++) push(rb(), rb(), 1'b0, rb(), m, w, 1);
        push(rb(), rb(), 1'b1, rb(), m, w, 1);
        push(rb(), rb(), rb(), rb(), m, w, 2);
        push(rb(), rb(), rb(), rb(), m, w, 3);
        if (m) begin
          for (int j = 0; j < dw; j++) push(rb(), rb(), rb(), 1'b0, m, w, 4);
          push(rb(), rb(), rb(), 1'b1, m, w, 4);
        end
        push(!last, rb(), rb(), rb(), m, w, 5);
        model_count++;
      end
      push(1'b0, 1'b0, rb(), rb(), rb(), rb(), 0);
      push(1'b0, 1'b0, rb(), rb(), rb(), rb(), 0);
      for (int i = 0; i < plan.size(); i++) begin
        run = plan[i].run; step = plan[i].step; imem_ready = plan[i].imem;
        dmem_ready = plan[i].dmem; mem_access = plan[i].mem; reg_write = plan[i].rw;
        @(negedge clk);
        checks++;
        if (obs !== plan[i].exp) begin
          errors++;
          $display("FAIL random trial %0d cycle %0d got=%h exp=%h", t, i, obs, plan[i].exp);
        end
        cycle();
      end
    end
    run = 1'b0; step = 1'b0;
  endtask

  task automatic test_memory_timeout();
    int ph;
    logic [15:0] e;
    run = 1'b0; step = 1'b1; imem_ready = 1'b1; dmem_ready = 1'b0;
    mem_access = 1'b1; reg_write = 1'b1;
    cycle();
    step = 1'b0;
    for (int i = 0; i < 21; i++) begin
      ph = (i < 3) ? i + 1 : (i < 18) ? 4 : 7;
      @(negedge clk);
      e = exp_obs(ph, 1'b1, 1'b1, (ph == 7), model_count);
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL mem_timeout cycle %0d got=%h exp=%h", i, obs, e);
      end
      cycle();
    end
    reset = 1'b0;
    cycle();
    model_count = 0;
    @(negedge clk);
    e = exp_obs(0, 1'b1, 1'b1, 1'b0, model_count);
    checks++;
    if (obs !== e) begin
      errors++;
      $display("FAIL mem_timeout_reset got=%h exp=%h", obs, e);
    end
    reset = 1'b1;
    cycle();
  endtask

  task automatic test_fetch_timeout();
    logic [15:0] e;
    run = 1'b0; step = 1'b1; imem_ready = 1'b0; dmem_ready = 1'b0;
    mem_access = 1'b0; reg_write = 1'b0;
    cycle();
    step = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      e = exp_obs(1, 1'b0, 1'b0, 1'b0, model_count);
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL fetch_wait cycle %0d got=%h exp=%h", i, obs, e);
      end
      cycle();
    end
    // ERROR holds regardless of run/step/ready activity
    for (int i = 0; i < 22; i++) begin
      run = rb(); step = rb(); imem_ready = rb(); dmem_ready = rb();
      @(negedge clk);
      e = exp_obs(7, imem_ready, 1'b0, 1'b1, model_count);
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL error_hold cycle %0d got=%h exp=%h", i, obs, e);
      end
      cycle();
    end
    reset = 1'b0;
    cycle();
    model_count = 0;
    @(negedge clk);
    e = exp_obs(0, imem_ready, 1'b0, 1'b0, model_count);
    checks++;
    if (obs !== e) begin
      errors++;
      $display("FAIL error_reset got=%h exp=%h", obs, e);
    end
    reset = 1'b1; run = 1'b0; step = 1'b0;
    cycle();
  endtask

  initial begin
    reset = 1'b0; run = 1'b0; step = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0;
    mem_access = 1'b0; reg_write = 1'b0;
    test_reset();
    test_continuous_run();
    test_single_step_memory();
    test_ready_wins();
    test_reset_mid_memory();
    test_wrap_and_stop();
    test_random_mix();
    test_memory_timeout();
    test_fetch_timeout();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
